adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 91 +++++++++
 tb/tb_adder_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester add/sub unit: round-robin arbitration into one shared adder,
// one operation in flight, fixed IDLE -> EXEC -> RESP sequence.
module adder_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_sub,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             grant_id;
    logic             op_sub;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             is_zero;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) grant_id = ~last_grant;
        req_ready = 2'b00;
        if (!reset && state == IDLE && req_valid != 2'b00) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        b_eff   = op_sub ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
        ovf     = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        is_zero = (sum[WIDTH-1:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_sub     <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            result     <= '0;
            flags      <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if ((req_valid & req_ready) != 2'b00) begin
                        a_q        <= grant_id ? req_a1 : req_a0;
                        b_q        <= grant_id ? req_b1 : req_b0;
                        op_sub     <= req_sub[grant_id];
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result     <= sum[WIDTH-1:0];
                    flags      <= {sum[WIDTH-1], is_zero, ovf, sum[WIDTH]};
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed stimulus with a response scoreboard; a negedge monitor checks
// every presented response for value, latency and stability under stall.
module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_sub;
    logic [63:0] req_a0, req_b0, req_a1, req_b1;
    logic        resp_valid, resp_ready, resp_id;
    logic [63:0] result;
    logic [3:0]  flags;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic [3:0]  flg;
        int          hs_cyc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    logic        prev_vld = 1'b0;
    logic        snap_id;
    logic [63:0] snap_res;
    logic [3:0]  snap_flg;

    adder_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_sub(req_sub), .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1),
        .req_b1(req_b1), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            prev_vld = 1'b0;
        end else begin
            if (resp_valid) begin
                chk("req_ready_in_resp", {62'd0, req_ready}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
                end else begin
                    if (!prev_vld) begin
                        chk("latency", cyc - sb[0].hs_cyc, 2);
                        snap_id = resp_id; snap_res = result; snap_flg = flags;
                    end else begin
                        chk("stall_id", {63'd0, resp_id}, {63'd0, snap_id});
                        chk("stall_result", result, snap_res);
                        chk("stall_flags", {60'd0, flags}, {60'd0, snap_flg});
                    end
                    if (resp_ready) begin
                        chk("resp_id", {63'd0, resp_id}, {63'd0, sb[0].id});
                        chk("result", result, sb[0].res);
                        chk("flags", {60'd0, flags}, {60'd0, sb[0].flg});
                        void'(sb.pop_front());
                    end
                end
            end
            prev_vld = resp_valid;
        end
    end

    task automatic issue(input logic id, input logic sub, input logic [63:0] a, b, res,
                         input logic [3:0] flg);
        logic got;
        @(posedge clk); #1;
        if (id) begin req_a1 = a; req_b1 = b; end
        else    begin req_a0 = a; req_b0 = b; end
        req_sub[id]   = sub;
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1'b1; break; end
        end
        chk("hs_timeout", {63'd0, got}, 64'd1);
        if (got) sb.push_back('{id: id, res: res, flg: flg, hs_cyc: cyc});
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        int   last_hs;
        reset = 1'b1; req_valid = 2'b11; req_sub = 2'b00; resp_ready = 1'b1;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        @(posedge clk); #1;
        req_valid = 2'b00; reset = 1'b0;

        issue(0, 0, 64'h0000000000000001, 64'h0FFFFFFFFFF00000, 64'h0FFFFFFFFFF00001, 4'b0000);
        drain();
        issue(1, 1, 64'd0, 64'd1, 64'hFFFFFFFFFFFFFFFF, 4'b1000);
        drain();
        issue(1, 1, 64'd5, 64'd5, 64'd0, 4'b0101);
        drain();
        issue(0, 0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 4'b0101);
        drain();

        // Backpressure: three stalled RESP cycles with r1 pending.
        resp_ready = 1'b0;
        issue(0, 0, 64'h8000000000000000, 64'h8000000000000000, 64'd0, 4'b0111);
        req_a1 = 64'd9; req_b1 = 64'd9; req_valid[1] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; break; end
        end
        chk("bp_resp_timeout", {63'd0, got}, 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        resp_ready = 1'b1; req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("bp_done", {63'd0, resp_valid}, 64'd0);
        drain();

        issue(0, 0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 4'b1010);
        drain();

        // Reset in EXEC: the in-flight op must vanish and r0 must win afterwards.
        @(posedge clk); #1;
        req_a0 = 64'h1234; req_b0 = 64'h1; req_sub[0] = 1'b0; req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[0]) begin got = 1'b1; break; end
        end
        chk("rst_hs_timeout", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 2'b11; req_sub = 2'b10;
        req_a0 = 64'd1; req_b0 = 64'd2; req_a1 = 64'd10; req_b1 = 64'd3;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_flags", {60'd0, flags}, 64'd0);
        chk("midrst_resp_id", {63'd0, resp_id}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Contention: both held valid, grants must alternate every 3 cycles.
        last_hs = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin got = 1'b1; break; end
            end
            chk("cont_timeout", {63'd0, got}, 64'd1);
            chk("cont_grant", {62'd0, req_ready}, (k % 2) ? 64'd2 : 64'd1);
            if (k > 0) chk("cont_interval", cyc - last_hs, 3);
            last_hs = cyc;
            if (k % 2) sb.push_back('{id: 1'b1, res: 64'd7, flg: 4'b0001, hs_cyc: cyc});
            else       sb.push_back('{id: 1'b0, res: 64'd3, flg: 4'b0000, hs_cyc: cyc});
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
